// File: rtl/z80_mem_ctrl.sv
// ---------------------------------------------------------------------------
// z80_mem_ctrl
//
// Memory-side bus responder for a Z80 core. It turns each CPU memory bus
// cycle into exactly one request on a req/ack backing memory. WAIT_L is held
// low until the access completes. Read data is returned through split
// data_out/data_oe ports. Refresh cycles and I/O cycles (MREQ_L high) are
// ignored.
//
// Parameters
//   WAIT_STATES  minimum cycles spent in REQ+STRETCH per access
//   TIMEOUT      REQ cycles without mem_ack before the access is aborted
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   addr_in, data_in             CPU address / write data (sampled at start)
//   MREQ_L, RD_L, WR_L, RFSH_L   CPU strobes, active low
//   WAIT_L                       low stretches the CPU bus cycle
//   data_out, data_oe            read data toward the CPU and its bus enable
//   mem_req, mem_we              backing memory request, 1 = write
//   mem_addr, mem_wdata          latched address / write data
//   mem_ack, mem_rdata           memory completion and same-cycle read data
//   err                          one-cycle pulse on timeout or protocol error
// ---------------------------------------------------------------------------
module z80_mem_ctrl #(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_in,
    input  logic [7:0]  data_in,
    input  logic        MREQ_L,
    input  logic        RD_L,
    input  logic        WR_L,
    input  logic        RFSH_L,
    output logic        WAIT_L,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        STRETCH,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_we_q, mem_we_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               data_oe_q, data_oe_d;

    logic               start;
    logic               proto_err;
    logic               strobes_idle;
    logic [CNT_W-1:0]   cnt_inc;
    logic               ws_met;
    logic               timeout_hit;

    // A valid memory cycle has exactly one of RD_L/WR_L low; both low is a
    // protocol error. Refresh cycles never qualify.
    assign start        = !MREQ_L && RFSH_L && (RD_L != WR_L);
    assign proto_err    = !MREQ_L && RFSH_L && !RD_L && !WR_L;
    assign strobes_idle = MREQ_L || (RD_L && WR_L);

    // cnt counts REQ+STRETCH cycles already spent; cnt_inc includes the
    // current one, which is what the exit tests need.
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign ws_met      = cnt_inc >= CNT_W'(WAIT_STATES);
    assign timeout_hit = cnt_inc == CNT_W'(TIMEOUT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mem_addr_d  = addr_in;
                    mem_we_d    = !WR_L;
                    mem_wdata_d = data_in;
                    cnt_d       = '0;
                    state_d     = REQ;
                end else if (proto_err) begin
                    err_d = 1'b1;
                end
            end
            REQ: begin
                cnt_d = cnt_inc;
                // An ack in the last allowed cycle wins over the timeout.
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = ws_met ? DONE : STRETCH;
                end else if (timeout_hit) begin
                    rdata_d = 8'hFF;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            STRETCH: begin
                cnt_d = cnt_inc;
                if (ws_met) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Waiting for the CPU to end its cycle keeps a long strobe
                // from issuing a second request.
                if (strobes_idle) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        data_oe_d = (state_d == DONE) && !mem_we_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            rdata_q     <= 8'h00;
            err_q       <= 1'b0;
            data_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            data_oe_q   <= data_oe_d;
        end
    end

    // WAIT_L drops in the same cycle the start is seen so the CPU cannot
    // complete the bus cycle before the request is issued. mem_req is gated
    // by rst so an in-flight request is withdrawn without waiting for the edge.
    assign WAIT_L    = !(((state_q == IDLE) && start) || (state_q == REQ) || (state_q == STRETCH));
    assign mem_req   = (state_q == REQ) && !rst;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign data_out  = rdata_q;
    assign data_oe   = data_oe_q;
    assign err       = err_q;

endmodule

// File: tb/tb_z80_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_z80_mem_ctrl
//
// Two instances share the CPU side: one with WAIT_STATES=1 and one with
// WAIT_STATES=4 (both TIMEOUT=16). Each has its own memory responder that
// acks after a chosen latency. Expected counts come from the access rules:
// WAIT_L low for 1 + max(latency, WAIT_STATES) cycles, or 1 + TIMEOUT on a
// timeout.
// ---------------------------------------------------------------------------
module tb_z80_mem_ctrl;

    localparam int TO  = 16;
    localparam int WS0 = 1;
    localparam int WS1 = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr_in;
    logic [7:0]  data_in;
    logic        mreq_l, rd_l, wr_l, rfsh_l;

    logic        wait_l    [2];
    logic [7:0]  data_out  [2];
    logic        data_oe   [2];
    logic        mem_req   [2];
    logic        mem_we    [2];
    logic [15:0] mem_addr  [2];
    logic [7:0]  mem_wdata [2];
    logic        mem_ack   [2];
    logic [7:0]  mem_rdata [2];
    logic        err       [2];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    z80_mem_ctrl #(.WAIT_STATES(WS0), .TIMEOUT(TO)) dut0 (
        .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
        .MREQ_L(mreq_l), .RD_L(rd_l), .WR_L(wr_l), .RFSH_L(rfsh_l),
        .WAIT_L(wait_l[0]), .data_out(data_out[0]), .data_oe(data_oe[0]),
        .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_ack(mem_ack[0]), .mem_rdata(mem_rdata[0]),
        .err(err[0])
    );

    z80_mem_ctrl #(.WAIT_STATES(WS1), .TIMEOUT(TO)) dut1 (
        .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
        .MREQ_L(mreq_l), .RD_L(rd_l), .WR_L(wr_l), .RFSH_L(rfsh_l),
        .WAIT_L(wait_l[1]), .data_out(data_out[1]), .data_oe(data_oe[1]),
        .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_ack(mem_ack[1]), .mem_rdata(mem_rdata[1]),
        .err(err[1])
    );

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int wsOf(input int i);
        return (i == 0) ? WS0 : WS1;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Both instances must show their post-reset output values.
    task automatic checkResetState(input string tag);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("%s.wait_l%0d", tag, i),    32'(wait_l[i]),    32'd1);
            checkOutput($sformatf("%s.data_oe%0d", tag, i),   32'(data_oe[i]),   32'd0);
            checkOutput($sformatf("%s.data_out%0d", tag, i),  32'(data_out[i]),  32'h00);
            checkOutput($sformatf("%s.mem_req%0d", tag, i),   32'(mem_req[i]),   32'd0);
            checkOutput($sformatf("%s.mem_we%0d", tag, i),    32'(mem_we[i]),    32'd0);
            checkOutput($sformatf("%s.mem_addr%0d", tag, i),  32'(mem_addr[i]),  32'h0000);
            checkOutput($sformatf("%s.mem_wdata%0d", tag, i), 32'(mem_wdata[i]), 32'h00);
            checkOutput($sformatf("%s.err%0d", tag, i),       32'(err[i]),       32'd0);
        end
    endtask

    // One CPU memory cycle. lat = REQ cycle in which memory acks (0 = never).
    // abort releases the strobes before the access finishes.
    task automatic applyStimulus(input string tag, input bit is_write,
                                 input logic [15:0] a, input logic [7:0] wd,
                                 input int lat0, input int lat1,
                                 input logic [7:0] rd0, input logic [7:0] rd1,
                                 input bit abort);
        int         lat [2];
        logic [7:0] rdv [2];
        bit         tmo [2];
        int         wexp [2];
        int         wcnt [2];
        int         rcnt [2];
        int         ecnt [2];
        int         ocnt [2];
        int         bad  [2];
        int         rel, last, wmin, wmax;
        bit         ack;

        lat[0] = lat0; lat[1] = lat1;
        rdv[0] = rd0;  rdv[1] = rd1;
        for (int i = 0; i < 2; i++) begin
            tmo[i]  = (lat[i] == 0) || (lat[i] > TO);
            wexp[i] = 1 + (tmo[i] ? TO : imax(lat[i], wsOf(i)));
            wcnt[i] = 0; rcnt[i] = 0; ecnt[i] = 0; ocnt[i] = 0; bad[i] = 0;
        end
        wmin = (wexp[0] < wexp[1]) ? wexp[0] : wexp[1];
        wmax = imax(wexp[0], wexp[1]);
        rel  = abort ? int'($urandom_range(wmin - 1, 1)) : wmax + int'($urandom_range(2, 0));
        last = imax(rel, wmax) + 3;

        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (c == 0) begin
                addr_in = a;
                data_in = wd;
                mreq_l  = 1'b0;
                rfsh_l  = 1'b1;
                rd_l    = is_write;
                wr_l    = !is_write;
            end else if (c == 1) begin
                addr_in = 16'($urandom);
                data_in = ~wd;
            end
            if (c == rel) begin
                mreq_l = 1'b1;
                rd_l   = 1'b1;
                wr_l   = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                ack          = mem_req[i] && (lat[i] != 0) && (rcnt[i] + 1 == lat[i]);
                mem_ack[i]   = ack;
                mem_rdata[i] = ack ? rdv[i] : 8'($urandom);
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                if (!wait_l[i]) wcnt[i]++;
                if (mem_req[i]) begin
                    rcnt[i]++;
                    if (mem_addr[i] != a || mem_we[i] != is_write || mem_wdata[i] != wd) bad[i]++;
                end
                if (err[i]) ecnt[i]++;
                if (data_oe[i]) ocnt[i]++;
                if (c == wexp[i] && !is_write)
                    checkOutput($sformatf("%s.data_out%0d", tag, i), 32'(data_out[i]),
                                tmo[i] ? 32'hFF : 32'(rdv[i]));
            end
        end
        mem_ack[0] = 1'b0;
        mem_ack[1] = 1'b0;

        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("%s.wait_cycles%0d", tag, i), 32'(wcnt[i]), 32'(wexp[i]));
            checkOutput($sformatf("%s.req_cycles%0d", tag, i),  32'(rcnt[i]), tmo[i] ? 32'(TO) : 32'(lat[i]));
            checkOutput($sformatf("%s.req_fields%0d", tag, i),  32'(bad[i]),  32'd0);
            checkOutput($sformatf("%s.err_pulses%0d", tag, i),  32'(ecnt[i]), 32'(tmo[i]));
            checkOutput($sformatf("%s.oe_cycles%0d", tag, i),   32'(ocnt[i]),
                        is_write ? 32'd0 : 32'(imax(rel, wexp[i]) - wexp[i] + 1));
        end
    endtask

    // Refresh, I/O-only and RD+WR-both-low cycles must never start an access.
    task automatic ignoredCycles();
        int wlow [2];
        int reqs [2];
        int errs [2];
        for (int i = 0; i < 2; i++) begin
            wlow[i] = 0; reqs[i] = 0; errs[i] = 0;
        end
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (c < 3) begin
                mreq_l = 1'b0; rfsh_l = 1'b0; rd_l = 1'b0; wr_l = 1'b1;
            end else if (c < 5) begin
                mreq_l = 1'b1; rfsh_l = 1'b1; rd_l = 1'b0; wr_l = 1'b1;
            end else if (c < 7) begin
                mreq_l = 1'b1; rfsh_l = 1'b1; rd_l = 1'b0; wr_l = 1'b0;
            end else if (c < 9) begin
                mreq_l = 1'b1; rfsh_l = 1'b1; rd_l = 1'b1; wr_l = 1'b1;
            end else if (c == 9) begin
                mreq_l = 1'b0; rfsh_l = 1'b1; rd_l = 1'b0; wr_l = 1'b0;
            end else begin
                mreq_l = 1'b1; rfsh_l = 1'b1; rd_l = 1'b1; wr_l = 1'b1;
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                if (!wait_l[i]) wlow[i]++;
                if (mem_req[i]) reqs[i]++;
                if (err[i]) errs[i]++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("ignored.wait_low%0d", i), 32'(wlow[i]), 32'd0);
            checkOutput($sformatf("ignored.req%0d", i),      32'(reqs[i]), 32'd0);
            checkOutput($sformatf("ignored.err%0d", i),      32'(errs[i]), 32'd1);
        end
    endtask

    // Reset in the middle of REQ, followed by an ack that must be discarded.
    task automatic resetDuringReq();
        @(negedge clk);
        addr_in = 16'h4321; data_in = 8'h77;
        mreq_l = 1'b0; rfsh_l = 1'b1; rd_l = 1'b0; wr_l = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mreq_l = 1'b1; rd_l = 1'b1; wr_l = 1'b1;
        #1;
        checkOutput("rst.req_drop0", 32'(mem_req[0]), 32'd0);
        checkOutput("rst.req_drop1", 32'(mem_req[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack[0] = 1'b1; mem_ack[1] = 1'b1;
        mem_rdata[0] = 8'h5A; mem_rdata[1] = 8'h5A;
        #1;
        checkResetState("rst.after");
        @(negedge clk);
        mem_ack[0] = 1'b0; mem_ack[1] = 1'b0;
        #1;
        checkResetState("rst.late_ack");
    endtask

    initial begin
        rst = 1'b1;
        addr_in = 16'h0000; data_in = 8'h00;
        mreq_l = 1'b1; rd_l = 1'b1; wr_l = 1'b1; rfsh_l = 1'b1;
        mem_ack[0] = 1'b0; mem_ack[1] = 1'b0;
        mem_rdata[0] = 8'h00; mem_rdata[1] = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b0;

        applyStimulus("read_min",  1'b0, 16'h1234, 8'h11, 1, 1, 8'h3C, 8'h3C, 1'b0);
        applyStimulus("write",     1'b1, 16'hBEEF, 8'hA5, 1, 1, 8'h00, 8'h00, 1'b0);
        applyStimulus("timeout",   1'b0, 16'h0F0F, 8'h00, 0, 0, 8'h00, 8'h00, 1'b0);
        applyStimulus("ack_last",  1'b0, 16'h8001, 8'h00, TO, TO, 8'hC3, 8'h96, 1'b0);
        applyStimulus("abort",     1'b0, 16'h2222, 8'h00, 3, 3, 8'h81, 8'h18, 1'b1);
        ignoredCycles();
        resetDuringReq();
        applyStimulus("post_rst",  1'b0, 16'h5678, 8'h00, 2, 2, 8'hE7, 8'h7E, 1'b0);

        for (int n = 0; n < 30; n++) begin
            int  l0, l1;
            bit  w, ab;
            w  = 1'($urandom);
            ab = ($urandom_range(3, 0) == 0);
            l0 = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(6, 1));
            l1 = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(6, 1));
            applyStimulus($sformatf("rand%0d", n), w, 16'($urandom), 8'($urandom),
                          l0, l1, 8'($urandom), 8'($urandom), ab);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard backstop in case something stalls the stimulus.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
